// File: rtl/line_buffer_window.sv
// Vertical window column generator: stores ROWS-1 previous lines in
// column-indexed memories and emits one masked ROWS-tall column per pixel.
module line_buffer_window #(
  parameter int DATA_W = 8,
  parameter int LINE_W = 640,
  parameter int ROWS   = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  output logic [ROWS*DATA_W-1:0]   out_col,
  output logic [$clog2(LINE_W)-1:0] out_x,
  output logic                     out_full
);

  localparam int XW = $clog2(LINE_W);
  localparam int YW = $clog2(ROWS);
  localparam int NL = ROWS - 1;

  logic [XW-1:0]          x;
  logic [XW-1:0]          x_cur;
  logic [YW-1:0]          y;
  logic [YW-1:0]          y_cur;
  logic                   last_col;
  logic                   wr_en;
  logic [DATA_W-1:0]      rd [NL];
  logic [ROWS*DATA_W-1:0] col_next;

  // A start-of-frame pixel always lands at the origin.
  assign x_cur    = (in_valid && in_sof) ? '0 : x;
  assign y_cur    = (in_valid && in_sof) ? '0 : y;
  assign last_col = (x_cur == XW'(LINE_W - 1));
  assign wr_en    = rst_n && in_valid;

  for (genvar k = 0; k < NL; k++) begin : g_line
    logic [DATA_W-1:0] mem [LINE_W];
    logic [DATA_W-1:0] wdata;

    assign rd[k] = mem[x_cur];

    if (k == 0) begin : g_head
      assign wdata = in_data;
    end else begin : g_tail
      assign wdata = rd[k-1];
    end

    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem[x_cur] <= wdata;
      end
    end
  end

  // Rows above the current frame's history read as zero.
  always_comb begin
    col_next = '0;
    col_next[DATA_W-1:0] = in_data;
    for (int j = 1; j < ROWS; j++) begin
      if (YW'(j) <= y_cur) begin
        col_next[j*DATA_W +: DATA_W] = rd[j-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (in_valid) begin
      if (last_col) begin
        x <= '0;
        if (y_cur != YW'(ROWS - 1)) begin
          y <= y_cur + 1'b1;
        end else begin
          y <= y_cur;
        end
      end else begin
        x <= x_cur + 1'b1;
        y <= y_cur;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_col   <= '0;
      out_x     <= '0;
      out_full  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_col  <= col_next;
        out_x    <= x_cur;
        out_full <= (y_cur == YW'(ROWS - 1));
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_window.sv
// Bench for line_buffer_window: directed frames plus randomized traffic
// checked against a frame-image reference model.
module tb_line_buffer_window;

  localparam int DW = 8;
  localparam int LW = 4;
  localparam int RW = 3;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [RW*DW-1:0] out_col;
  logic [1:0]    out_x;
  logic          out_full;

  line_buffer_window #(.DATA_W(DW), .LINE_W(LW), .ROWS(RW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
    .in_data(in_data), .out_valid(out_valid), .out_col(out_col),
    .out_x(out_x), .out_full(out_full)
  );

  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  int ly;
  int mx;
  logic [DW-1:0] pix [64][LW];
  logic          exp_v;
  logic [RW*DW-1:0] exp_col;
  logic [1:0]    exp_x;
  logic          exp_full;
  logic [RW*DW-1:0] ref_q [$];

  // Model keeps every pixel of the current frame by (line, column).
  task automatic step(input logic r, input logic v, input logic s,
                      input logic [DW-1:0] d);
    rst_n = r; in_valid = v; in_sof = s; in_data = d;
    @(posedge clk);
    #1;
    if (!r) begin
      ly = 0; mx = 0;
      exp_v = 0; exp_col = '0; exp_x = '0; exp_full = 0;
    end else if (v) begin
      if (s) begin
        ly = 0; mx = 0;
      end
      pix[ly][mx] = d;
      exp_col = '0;
      for (int j = 0; j < RW; j++)
        if (j <= ly) exp_col[j*DW +: DW] = pix[ly-j][mx];
      exp_x = 2'(mx);
      exp_full = (ly >= RW - 1);
      exp_v = 1;
      if (mx == LW - 1) begin
        mx = 0; ly++;
      end else begin
        mx++;
      end
    end else begin
      exp_v = 0;
    end
  endtask

  task automatic test_reset();
    step(0, 1, 1, 8'hAA);
    step(0, 0, 0, 8'h00);
    n_chk++;
    if ({out_valid, out_col, out_x, out_full} !== '0) begin
      n_fail++;
      $display("FAIL reset: got v=%0b col=%h x=%0d full=%0b want all 0",
               out_valid, out_col, out_x, out_full);
    end
  endtask

  task automatic test_frame();
    ref_q.delete();
    for (int p = 1; p <= 12; p++) begin
      step(1, 1, p == 1, 8'(p));
      ref_q.push_back(exp_col);
      n_chk++;
      if ({out_valid, out_col, out_x, out_full} !==
          {exp_v, exp_col, exp_x, exp_full}) begin
        n_fail++;
        $display("FAIL frame p%0d: got v=%0b col=%h x=%0d f=%0b want v=%0b col=%h x=%0d f=%0b",
                 p, out_valid, out_col, out_x, out_full,
                 exp_v, exp_col, exp_x, exp_full);
      end
      if (p <= 8) begin
        n_chk++;
        if (out_full !== 1'b0) begin
          n_fail++;
          $display("FAIL early_full p%0d: got %0b want 0", p, out_full);
        end
      end
      if (p == 2) begin
        n_chk++;
        if ({out_col, out_x} !== {8'd0, 8'd0, 8'd2, 2'd1}) begin
          n_fail++;
          $display("FAIL pix2: got col=%h x=%0d want 000002 x=1", out_col, out_x);
        end
      end
      if (p == 5) begin
        n_chk++;
        if ({out_col, out_x} !== {8'd0, 8'd1, 8'd5, 2'd0}) begin
          n_fail++;
          $display("FAIL pix5: got col=%h x=%0d want 000105 x=0", out_col, out_x);
        end
      end
      if (p == 9) begin
        n_chk++;
        if ({out_col, out_x, out_full} !== {8'd1, 8'd5, 8'd9, 2'd0, 1'b1}) begin
          n_fail++;
          $display("FAIL pix9: got col=%h x=%0d f=%0b want 010509 x=0 f=1",
                   out_col, out_x, out_full);
        end
      end
    end
    for (int p = 101; p <= 112; p++) begin
      step(1, 1, p == 101, 8'(p));
      n_chk++;
      if ({out_valid, out_col, out_x, out_full} !==
          {exp_v, exp_col, exp_x, exp_full}) begin
        n_fail++;
        $display("FAIL frame2 p%0d: got col=%h x=%0d f=%0b want col=%h x=%0d f=%0b",
                 p, out_col, out_x, out_full, exp_col, exp_x, exp_full);
      end
      if (p == 101) begin
        n_chk++;
        if ({out_col, out_full} !== {8'd0, 8'd0, 8'd101, 1'b0}) begin
          n_fail++;
          $display("FAIL pix101: got col=%h f=%0b want 000065 f=0", out_col, out_full);
        end
      end
    end
  endtask

  task automatic test_gaps();
    logic [RW*DW-1:0] held;
    int idx;
    idx = 0;
    for (int p = 1; p <= 12; p++) begin
      step(1, 1, p == 1, 8'(p));
      n_chk++;
      if (out_valid !== 1'b1 || out_col !== ref_q[idx]) begin
        n_fail++;
        $display("FAIL gap_seq p%0d: got v=%0b col=%h want v=1 col=%h",
                 p, out_valid, out_col, ref_q[idx]);
      end
      idx++;
      held = out_col;
      for (int g = 0; g < int'($urandom_range(3, 1)); g++) begin
        step(1, 0, $urandom_range(1, 0) == 1, 8'($urandom));
        n_chk++;
        if (out_valid !== 1'b0 || out_col !== held ||
            {out_x, out_full} !== {exp_x, exp_full}) begin
          n_fail++;
          $display("FAIL gap_hold p%0d: got v=%0b col=%h x=%0d want v=0 col=%h x=%0d",
                   p, out_valid, out_col, out_x, held, exp_x);
        end
      end
    end
  endtask

  task automatic test_mid_sof_reset();
    for (int p = 0; p < 6; p++) step(1, 1, p == 0, 8'(p + 20));
    step(1, 1, 1, 8'h77);
    n_chk++;
    if ({out_col, out_x} !== {8'd0, 8'd0, 8'h77, 2'd0}) begin
      n_fail++;
      $display("FAIL mid_sof: got col=%h x=%0d want 000077 x=0", out_col, out_x);
    end
    step(1, 1, 0, 8'h78);
    step(0, 1, 0, 8'h79);
    n_chk++;
    if ({out_valid, out_col, out_x, out_full} !== '0) begin
      n_fail++;
      $display("FAIL mid_rst: got v=%0b col=%h x=%0d f=%0b want all 0",
               out_valid, out_col, out_x, out_full);
    end
    step(1, 1, 0, 8'h7A);
    n_chk++;
    if ({out_valid, out_col, out_x} !== {1'b1, 8'd0, 8'd0, 8'h7A, 2'd0}) begin
      n_fail++;
      $display("FAIL post_rst: got v=%0b col=%h x=%0d want v=1 col=00007a x=0",
               out_valid, out_col, out_x);
    end
  endtask

  task automatic test_stream();
    for (int p = 0; p < 10 * LW; p++) begin
      step(1, 1, p == 0, 8'($urandom));
      n_chk++;
      if ({out_valid, out_col, out_x, out_full} !==
          {exp_v, exp_col, exp_x, exp_full}) begin
        n_fail++;
        $display("FAIL stream p%0d: got col=%h x=%0d f=%0b want col=%h x=%0d f=%0b",
                 p, out_col, out_x, out_full, exp_col, exp_x, exp_full);
      end
      n_chk++;
      if (out_full !== (p >= 2 * LW) || out_x !== 2'(p % LW)) begin
        n_fail++;
        $display("FAIL stream_full p%0d: got f=%0b x=%0d want f=%0b x=%0d",
                 p, out_full, out_x, p >= 2 * LW, p % LW);
      end
    end
  endtask

  task automatic test_random();
    logic r, v, s;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(99, 0) != 0);
      v = ($urandom_range(3, 0) != 0);
      s = ($urandom_range(29, 0) == 0) || (ly >= 60);
      step(r, v, s, 8'($urandom));
      n_chk++;
      if ({out_valid, out_col, out_x, out_full} !==
          {exp_v, exp_col, exp_x, exp_full}) begin
        n_fail++;
        $display("FAIL random c%0d: got v=%0b col=%h x=%0d f=%0b want v=%0b col=%h x=%0d f=%0b",
                 i, out_valid, out_col, out_x, out_full,
                 exp_v, exp_col, exp_x, exp_full);
      end
    end
  endtask

  initial begin
    clk = 0; rst_n = 0; in_valid = 0; in_sof = 0; in_data = '0;
    n_chk = 0; n_fail = 0;
    ly = 0; mx = 0;
    exp_v = 0; exp_col = '0; exp_x = '0; exp_full = 0;
    test_reset();
    test_frame();
    test_gaps();
    test_mid_sof_reset();
    test_stream();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/line_buffer_window.md
LINE_BUFFER_WINDOW -- requirements
Module: line_buffer_window

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning pixel width in bits.
REQ-002 The block SHALL have parameter LINE_W, default 640, meaning pixels per line (2..4096).
REQ-003 The block SHALL have parameter ROWS, default 5, meaning window height in lines (2..8).
REQ-004 The block SHALL derive localparam XW = clog2(LINE_W) and YW = clog2(ROWS).
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, meaning synchronous active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1, meaning in_data carries a pixel this cycle.
REQ-008 The block SHALL have port in_sof, input, 1, meaning the current pixel is the first of a frame; qualified by in_valid.
REQ-009 The block SHALL have port in_data, input, DATA_W, meaning the pixel, raster order.
REQ-010 The block SHALL have port out_valid, output, 1, meaning the window column outputs are valid.
REQ-011 The block SHALL have port out_col, output, ROWS*DATA_W, meaning the vertical window column; slice j (bits j*DATA_W +: DATA_W) is the pixel j lines above the current one, same column.
REQ-012 The block SHALL have port out_x, output, XW, meaning column index of the slice-0 pixel.
REQ-013 The block SHALL have port out_full, output, 1, meaning all ROWS slices hold real pixels of the current frame.

Function
REQ-014 The block SHALL store ROWS-1 lines in LINE_W-deep memories indexed by column (RAM-inferable, no full-line shift registers).
REQ-015 On each cycle with in_valid=1 at column x, the block SHALL read line k at x, write in_data to line 0 at x, and write old line k-1 content to line k at x (read-before-write).
REQ-016 Slice 0 of out_col SHALL be in_data; slice j (j>=1) SHALL be the pixel read from line j-1 at x.
REQ-017 Latency SHALL be exactly one cycle: out_valid, out_col, out_x, out_full register in_valid-qualified data from the previous cycle.
REQ-018 Column counter x SHALL advance by 1 per valid pixel and wrap LINE_W-1 -> 0; on wrap, line counter y SHALL increment, saturating at ROWS-1.
REQ-019 A valid pixel with in_sof=1 SHALL be processed at x=0, y=0, regardless of prior counter state (mid-line sof allowed).
REQ-020 in_sof with in_valid=0 SHALL be ignored.
REQ-021 Slice j SHALL output all zeros when j > y for that pixel (lines not yet received this frame, including stale data from previous frame).
REQ-022 out_full SHALL be 1 iff y = ROWS-1 for the output pixel.
REQ-023 When in_valid=0 the block SHALL hold counters and memories unchanged and drive out_valid=0 next cycle; out_col, out_x, out_full SHALL hold their last values.
REQ-024 Memory contents SHALL NOT depend on reset; correctness after reset relies on REQ-021 masking.

Reset
REQ-025 With rst_n=0 at a clock edge, x, y SHALL clear to 0 and out_valid, out_col, out_x, out_full SHALL clear to 0.
REQ-026 Reset asserted mid-line SHALL abandon the line; the first valid pixel after release SHALL be treated as x=0, y=0 with or without in_sof.
REQ-027 rst_n has priority over in_valid and in_sof in the same cycle.

Verification (LINE_W=4, ROWS=3, DATA_W=8)
REQ-028 Frame of 3 lines, pixels 1..12, in_sof on pixel 1 -> pixel 9 output one cycle later: out_col slices {0:9,1:5,2:1}, out_x=0, out_full=1; pixels 1..8 out_full=0.
REQ-029 Same frame -> pixel 5 output: slices {0:5,1:1,2:0}, out_x=0; pixel 2: slices {0:2,1:0,2:0}, out_x=1.
REQ-030 Second frame values 101..112 after first with in_sof -> pixel 101 slices {0:101,1:0,2:0} (stale 9/5 masked), out_full=0.
REQ-031 in_valid gaps of 1..3 cycles between every pixel -> identical out_col sequence as gapless run; out_valid=0 in gap cycles with outputs held.
REQ-032 in_sof at x=2 of line 1 -> that pixel out_x=0, slices 1,2 zero; rst_n=0 for one cycle mid-line -> all outputs 0 next cycle, next pixel out_x=0.
REQ-033 Continuous 10-line stream -> y saturates, out_full stays 1 from line 3 onward, wrap 3->0 each line.
